mac_ram_array: RTL

Parametrised RAM-backed multiply-accumulate bank for the correlator datapath: holds 2**DEPTH_LOG2 accumulators in one block RAM and, per sample, adds A*B(k) into entry k while B streams one lag per cycle. It adds configurable widths, signed/unsigned mode, a pipelined read-modify-write sweep, busy/done handshake, a registered read port with valid, and overflow and missed-sample flags. It sits between the lag shift register, which feeds B, and the host readout.

---
 rtl/mac_ram_array_if.sv | 32 +++
 rtl/mac_ram_array.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mac_ram_array_if.sv
// Host/datapath bus for mac_ram_array: sweep control, lag stream, readout port
// and status flags. The master side is the host plus lag shift register; the
// slave side is the accumulator bank.
interface mac_ram_array_if #(
  parameter int DW         = 8,
  parameter int AW         = 32,
  parameter int DEPTH_LOG2 = 7
);
  logic                  sin;
  logic                  clr;
  logic                  signed_mode;
  logic [DW-1:0]         a;
  logic [DW-1:0]         b;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [AW-1:0]         rd_data;
  logic                  rd_valid;
  logic                  ovf;
  logic                  miss;

  modport master (
    output sin, clr, signed_mode, a, b, rd_en, rd_addr,
    input  busy, done, rd_data, rd_valid, ovf, miss
  );

  modport slave (
    input  sin, clr, signed_mode, a, b, rd_en, rd_addr,
    output busy, done, rd_data, rd_valid, ovf, miss
  );
endinterface

// File: rtl/mac_ram_array.sv
// RAM-backed multiply-accumulate bank: 2**DEPTH_LOG2 accumulators in one
// block RAM. Each accepted sample strobe sweeps every entry k, adding a*b(k)
// through a two-stage read-modify-write pipeline; a clear sweep zeroes the
// bank. Reads are served from the same RAM port while idle.
// Optional build macro: MACRAM_SAT_EN -- saturate instead of wrapping on
// accumulator overflow (ovf is set in both builds).
// AW must be at least 2*DW. The RAM relies on the configuration image being
// all-zero; reset deliberately leaves its contents untouched.
module mac_ram_array #(
  parameter int DW         = 8,
  parameter int AW         = 32,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_ram_array_if.slave   bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_miss;
  logic [DW-1:0]         r_a;
  logic                  r_sm;

  logic [DW-1:0]         r_b;
  logic                  r_wr_pend;
  logic [DEPTH_LOG2-1:0] r_wr_addr;
  logic                  r_rd_p1;
  logic                  r_rd_valid;
  logic [AW-1:0]         r_rd_data;

  logic [AW-1:0]         r_mem [DEPTH];
  logic [AW-1:0]         r_ram_q;

  // Acceptance: a MAC drain cycle (IDLE with busy still up) accepts nothing.
  logic w_idle, w_acc_rd, w_last;
  assign w_idle   = (r_state == S_IDLE) && !r_busy;
  assign w_acc_rd = w_idle && !bus.sin && !bus.clr && bus.rd_en;
  assign w_last   = &r_idx;

  // During MAC the RAM port walks idx; otherwise it serves host reads.
  logic [DEPTH_LOG2-1:0] w_raddr;
  assign w_raddr = (r_state == S_MAC) ? r_idx : bus.rd_addr;

  // Product: widen both operands to 2*DW so the low 2*DW bits are exact for
  // either signedness.
  logic [2*DW-1:0] w_ua, w_ub, w_sa, w_sb, w_prod;
  assign w_ua   = {{DW{1'b0}}, r_a};
  assign w_ub   = {{DW{1'b0}}, r_b};
  assign w_sa   = {{DW{r_a[DW-1]}}, r_a};
  assign w_sb   = {{DW{r_b[DW-1]}}, r_b};
  assign w_prod = r_sm ? (w_sa * w_sb) : (w_ua * w_ub);

  logic [AW-1:0] w_ext, w_sum, w_wr_mac;
  logic [AW:0]   w_sum_full;
  logic          w_ovf_u, w_ovf_s, w_ovf;
  assign w_ext      = r_sm ? AW'($signed(w_prod)) : AW'(w_prod);
  assign w_sum_full = {1'b0, r_ram_q} + {1'b0, w_ext};
  assign w_sum      = w_sum_full[AW-1:0];
  assign w_ovf_u    = w_sum_full[AW];
  assign w_ovf_s    = (r_ram_q[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != r_ram_q[AW-1]);
  assign w_ovf      = r_sm ? w_ovf_s : w_ovf_u;

`ifdef MACRAM_SAT_EN
  // Clamp toward the shared operand sign (signed) or all-ones (unsigned).
  always_comb begin
    w_wr_mac = w_sum;
    if (w_ovf) begin
      if (!r_sm)               w_wr_mac = {AW{1'b1}};
      else if (r_ram_q[AW-1])  w_wr_mac = {1'b1, {(AW-1){1'b0}}};
      else                     w_wr_mac = {1'b0, {(AW-1){1'b1}}};
    end
  end
`else
  assign w_wr_mac = w_sum;
`endif

  // Single write port: pending MAC write-back, or a zero during clear.
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_waddr;
  logic [AW-1:0]         w_wdata;
  assign w_we    = r_wr_pend || (r_state == S_CLR);
  assign w_waddr = r_wr_pend ? r_wr_addr : r_idx;
  assign w_wdata = r_wr_pend ? w_wr_mac : '0;

  // Sweep controller: state, index, handshake and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_miss  <= 1'b0;
      r_a     <= '0;
      r_sm    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.sin && r_busy)  r_miss <= 1'b1;
      if (r_wr_pend && w_ovf) r_ovf  <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_idx  <= '0;
          if (!r_busy) begin
            if (bus.sin) begin
              r_a     <= bus.a;
              r_sm    <= bus.signed_mode;
              r_state <= S_MAC;
              r_busy  <= 1'b1;
            end else if (bus.clr) begin
              r_state <= S_CLR;
              r_busy  <= 1'b1;
            end
          end
        end
        S_MAC: begin
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            // Last write-back still follows next cycle; busy holds until then.
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_CLR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == DEPTH_LOG2'(DEPTH - 2)) r_done <= 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_miss  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath pipeline: lag capture, write-back tag and read-port staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b        <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_pend  <= (r_state == S_MAC);
      r_wr_addr  <= r_idx;
      if (r_state == S_MAC) r_b <= bus.b;
      r_rd_p1    <= w_acc_rd;
      r_rd_valid <= r_rd_p1;
      if (r_rd_p1) r_rd_data <= r_ram_q;
    end
  end

  // Block RAM write port.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Block RAM registered read port.
  always_ff @(posedge clk) begin
    r_ram_q <= r_mem[w_raddr];
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.ovf      = r_ovf;
  assign bus.miss     = r_miss;
endmodule
